// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU selects and aluop encodings.
`default_nettype none

package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SRLV = 6'b000110;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SRLV = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_control_unit_alu_decoder.sv
// ALU select decoder: maps aluop/funct to the 3-bit ALU select and flags
// whether funct names a supported R-type operation.
`default_nettype none

module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_ok
);

   logic [2:0] funct_sel;

   // funct_ok is independent of aluop so DECODE can flag a bad funct early.
   always_comb begin
      funct_ok  = 1'b1;
      funct_sel = ALU_ADD;
      case (funct)
         FN_ADD:  funct_sel = ALU_ADD;
         FN_SUB:  funct_sel = ALU_SUB;
         FN_AND:  funct_sel = ALU_AND;
         FN_OR:   funct_sel = ALU_OR;
         FN_SLT:  funct_sel = ALU_SLT;
         FN_SRLV: funct_sel = ALU_SRLV;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: alucontrol = funct_sel;
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mips_control_unit.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and
// strobes, with ALU select from alu_decoder and pcen from pcwrite/branch/zero.
`default_nettype none

module mips_control_unit
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   state_t     state_q, state_d;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;
   logic       funct_ok;
   logic       op_ok;
   logic       instr_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
         default:                                       op_ok = 1'b0;
      endcase
   end

   assign instr_ok = op_ok && ((op != OP_RTYPE) || funct_ok);

   always_comb begin
      state_d  = state_q;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = ALUOP_ADD;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            illegal = !instr_ok;
            // Unsupported instructions fall straight back to FETCH.
            if (!instr_ok)             state_d = S_FETCH;
            else if (op == OP_RTYPE)   state_d = S_EXECUTE;
            else if (op == OP_BEQ)     state_d = S_BRANCH;
            else if (op == OP_ADDI)    state_d = S_ADDIEX;
            else if (op == OP_J)       state_d = S_JUMP;
            else                       state_d = S_MEMADR;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign pcen = pcwrite | (branch & zero);

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol),
      .funct_ok   (funct_ok)
   );

endmodule

`default_nettype wire

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: directed and random instruction
// streams compared cycle by cycle against an instruction-level reference model.
`default_nettype none

module tb_mips_control_unit;

   typedef int phase_q_t[$];

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_MEMADR = 2;
   localparam int P_MEMRD  = 3;
   localparam int P_MEMWB  = 4;
   localparam int P_MEMWR  = 5;
   localparam int P_EXEC   = 6;
   localparam int P_ALUWB  = 7;
   localparam int P_BRANCH = 8;
   localparam int P_ADDIEX = 9;
   localparam int P_ADDIWB = 10;
   localparam int P_JUMP   = 11;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       pcen;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [15:0] obs;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   mips_control_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_legal(logic [5:0] o, logic [5:0] f);
      if (o == 6'b000000)
         return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                (f == 6'b100101) || (f == 6'b101010) || (f == 6'b000110);
      return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000100) ||
             (o == 6'b001000) || (o == 6'b000010);
   endfunction

   function automatic logic [2:0] alu_ref(logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b000110: return 3'b011;
         default:   return 3'b010;
      endcase
   endfunction

   // Sequence of steps an instruction walks through, FETCH first.
   function automatic phase_q_t phases(logic [5:0] o, logic [5:0] f);
      phase_q_t q;
      q.push_back(P_FETCH);
      q.push_back(P_DECODE);
      if (!is_legal(o, f)) return q;
      case (o)
         6'b100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
         6'b101011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
         6'b000000: begin q.push_back(P_EXEC);   q.push_back(P_ALUWB); end
         6'b000100: q.push_back(P_BRANCH);
         6'b001000: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
         default:   q.push_back(P_JUMP);
      endcase
      return q;
   endfunction

   function automatic logic [15:0] exp_vec(int ph, logic [5:0] o, logic [5:0] f, logic z);
      logic iord_e = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
      logic pw = 0, br = 0, ill = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] ac = 3'b010;
      case (ph)
         P_FETCH:  begin irw = 1; pw = 1; sb = 2'b01; end
         P_DECODE: begin sb = 2'b11; ill = !is_legal(o, f); end
         P_MEMADR: begin sa = 1; sb = 2'b10; end
         P_MEMRD:  iord_e = 1;
         P_MEMWB:  begin m2r = 1; rw = 1; end
         P_MEMWR:  begin iord_e = 1; mw = 1; end
         P_EXEC:   begin sa = 1; ac = alu_ref(f); end
         P_ALUWB:  begin rd = 1; rw = 1; end
         P_BRANCH: begin sa = 1; ps = 2'b01; br = 1; ac = 3'b110; end
         P_ADDIEX: begin sa = 1; sb = 2'b10; end
         P_ADDIWB: rw = 1;
         default:  begin ps = 2'b10; pw = 1; end
      endcase
      return {iord_e, mw, irw, rd, m2r, rw, sa, sb, ps, pw | (br & z), ac, ill};
   endfunction

   task automatic check(string tag, logic [15:0] got, logic [15:0] want);
      n_total++;
      assert (got === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   // Runs one instruction; zmode -1 randomizes zero. abort_at >= 0 pulls
   // rst_n low during that step and leaves the FSM in FETCH with reset released.
   task automatic run_instr(string name, logic [5:0] o, logic [5:0] f, int zmode, int abort_at);
      phase_q_t q = phases(o, f);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         op    = o;
         funct = f;
         zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         #1;
         check($sformatf("%s step%0d", name, i), obs, exp_vec(q[i], o, f, zero));
         if (i == abort_at) begin
            #1 rst_n = 1'b0;
            #1 check($sformatf("%s async reset", name), obs, exp_vec(P_FETCH, o, f, zero));
            check($sformatf("%s memwrite held low", name), {15'd0, memwrite}, 16'd0);
            @(posedge clk);
            #2 check($sformatf("%s reset held", name), obs, exp_vec(P_FETCH, o, f, zero));
            rst_n = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[6];
      logic [5:0] o, f;
      int r;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000110};

      rst_n = 1'b0;
      op    = 6'b100011;
      funct = 6'b000000;
      zero  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2 check($sformatf("reset edge%0d", i), obs, exp_vec(P_FETCH, op, funct, zero));
      end
      rst_n = 1'b1;

      run_instr("lw",        6'b100011, 6'b000000, -1, -1);
      run_instr("srlv",      6'b000000, 6'b000110, -1, -1);
      run_instr("beq_z1",    6'b000100, 6'b000000,  1, -1);
      run_instr("beq_z0",    6'b000100, 6'b000000,  0, -1);
      run_instr("bad_op",    6'b111111, 6'b000000, -1, -1);
      run_instr("bad_funct", 6'b000000, 6'b111111, -1, -1);
      run_instr("sw_abort",  6'b101011, 6'b000000, -1,  2);
      run_instr("sw",        6'b101011, 6'b000000, -1, -1);
      run_instr("addi",      6'b001000, 6'b000000, -1, -1);
      run_instr("j",         6'b000010, 6'b000000, -1, -1);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         f = 6'($urandom);
         if (r < 6) begin
            o = ops[r];
            if (o == 6'b000000) f = fns[$urandom_range(0, 5)];
         end else if (r < 8) begin
            o = 6'b000000;
         end else begin
            o = 6'($urandom);
         end
         run_instr($sformatf("rnd%0d op=%b fn=%b", n, o, f), o, f, -1, -1);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
